fpga_result_uart: RTL and testbench

// - Downstream of the FPGA test-monitor stage. Consumes its one-shot test-complete event, pass/fail verdict and cycle count.
// - Transmits a single ASCII result line over a UART TX pin, so board runs report results without a debugger.
// - Sits at FPGA top level, beside the LEDs, fed by the monitor's test_completed/led_pass/cycle_count.

---
 rtl/fpga_result_uart.sv | 158 +++++++++++++++
 tb/tb_fpga_result_uart.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_result_uart.sv
// Sends one ASCII result line ("PASS "/"FAIL ", 8 hex digits of the cycle count, CR LF)
// over an 8N1 UART when the test monitor's done level rises; one-shot until reset.
module fpga_result_uart #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        done_i,
    input  logic        pass_i,
    input  logic [31:0] cycles_i,
    output logic        uart_tx_o,
    output logic        busy_o,
    output logic        sent_o
);

    localparam int BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  char_q, char_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        sent_q, sent_d;
    logic        done_q;
    logic        pass_q;
    logic [31:0] cycles_q;
    logic        latch;
    logic        baud_wrap;
    logic [2:0]  nib_idx;
    logic [3:0]  nib;
    logic [7:0]  char_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // Characters 5..12 carry nibbles 7..0 of the latched count, MSB first.
    always_comb begin
        nib_idx = 3'(4'd12 - char_q);
        nib     = cycles_q[{nib_idx, 2'b00} +: 4];
        case (char_q)
            4'd0:    char_byte = pass_q ? 8'h50 : 8'h46;
            4'd1:    char_byte = 8'h41;
            4'd2:    char_byte = pass_q ? 8'h53 : 8'h49;
            4'd3:    char_byte = pass_q ? 8'h53 : 8'h4C;
            4'd4:    char_byte = 8'h20;
            4'd13:   char_byte = 8'h0D;
            4'd14:   char_byte = 8'h0A;
            default: char_byte = hex_ascii(nib);
        endcase
    end

    assign baud_wrap = (baud_q == CNT_W'(BAUD_DIV - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        sent_d  = sent_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_i && !done_q && !sent_q) begin
                    latch   = 1'b1;
                    char_d  = 4'd0;
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = char_byte[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = char_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (char_q < 4'd14) begin
                        char_d  = char_q + 4'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        // busy drops as the last stop bit ends, not a clock later.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        sent_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            char_q   <= 4'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            cycles_q <= 32'd0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
            done_q  <= done_i;
            if (latch) begin
                pass_q   <= pass_i;
                cycles_q <= cycles_i;
            end
        end
    end

    assign uart_tx_o = tx_q;
    assign busy_o    = busy_q;
    assign sent_o    = sent_q;

endmodule

// File: tb/tb_fpga_result_uart.sv
// Bench for fpga_result_uart at BAUD_DIV=10: a mid-bit UART decoder checks received
// characters against an expected-character queue, plus timing and one-shot checks.
module tb_fpga_result_uart;

    logic        clk;
    logic        rst_n;
    logic        done_i;
    logic        pass_i;
    logic [31:0] cycles_i;
    logic        uart_tx_o;
    logic        busy_o;
    logic        sent_o;

    logic [7:0] exp_q[$];
    int tests;
    int fails;

    fpga_result_uart #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done_i    (done_i),
        .pass_i    (pass_i),
        .cycles_i  (cycles_i),
        .uart_tx_o (uart_tx_o),
        .busy_o    (busy_o),
        .sent_o    (sent_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 800000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'd48 + {4'd0, n};
        else return 8'd65 + {4'd0, n} - 8'd10;
    endfunction

    task automatic push_expected(input logic p, input logic [31:0] c);
        string s;
        s = p ? "PASS " : "FAIL ";
        for (int i = 0; i < 5; i++) exp_q.push_back(s[i]);
        for (int i = 0; i < 8; i++) exp_q.push_back(hex_char(c[(31 - 4 * i) -: 4]));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Decodes n frames at mid-bit and compares each against the queue head.
    task automatic rx_message(input int n_chars);
        for (int k = 0; k < n_chars; k++) begin
            int waited;
            logic start_bit, stop_bit;
            logic [7:0] data, e;
            waited = 0;
            while (uart_tx_o !== 1'b0 && waited < 3000) begin
                tick();
                waited++;
            end
            tests++;
            if (uart_tx_o !== 1'b0) begin
                fails++;
                $display("FAIL rx_timeout char %0d: tx got %b required 0 within 3000 clocks", k, uart_tx_o);
                return;
            end
            repeat (4) tick();
            start_bit = uart_tx_o;
            for (int b = 0; b < 8; b++) begin
                repeat (10) tick();
                data[b] = uart_tx_o;
            end
            repeat (10) tick();
            stop_bit = uart_tx_o;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rx_unexpected: got char %h, required none", data);
            end else begin
                e = exp_q.pop_front();
                if (data !== e || start_bit !== 1'b0 || stop_bit !== 1'b1) begin
                    fails++;
                    $display("FAIL rx_char[%0d]: got %h start %b stop %b, required %h start 0 stop 1",
                             k, data, start_bit, stop_bit, e);
                end
            end
        end
    endtask

    task automatic wait_sent(input string name);
        int w;
        w = 0;
        while (sent_o !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        tests++;
        if (sent_o !== 1'b1 || busy_o !== 1'b0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_end: got sent %b busy %b pending %0d, required sent 1 busy 0 pending 0",
                     name, sent_o, busy_o, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic apply_reset();
        done_i = 1'b0;
        rst_n  = 1'b0;
        repeat (3) tick();
        tests++;
        if (uart_tx_o !== 1'b1 || busy_o !== 1'b0 || sent_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got tx %b busy %b sent %b, required tx 1 busy 0 sent 0",
                     uart_tx_o, busy_o, sent_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        pass_i   = 1'b0;
        cycles_i = 32'd0;
        apply_reset();
        repeat (20) tick();
        tests++;
        if (uart_tx_o !== 1'b1 || busy_o !== 1'b0 || sent_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got tx %b busy %b sent %b, required tx 1 busy 0 sent 0",
                     uart_tx_o, busy_o, sent_o);
        end
    endtask

    task automatic test_pass_message();
        int busy_cnt;
        int runs[6];
        int bad_runs;
        apply_reset();
        pass_i   = 1'b1;
        cycles_i = 32'h00001A2F;
        push_expected(1'b1, 32'h00001A2F);
        done_i = 1'b1;
        tick();
        tests++;
        if (uart_tx_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL start_latency: got tx %b busy %b, required tx 0 busy 1", uart_tx_o, busy_o);
        end
        busy_cnt = 0;
        bad_runs = 0;
        fork
            rx_message(15);
            begin
                while (busy_o === 1'b1 && busy_cnt < 2000) begin
                    tick();
                    busy_cnt++;
                end
            end
            begin
                logic level;
                int run, idx;
                level = 1'b0;
                run = 1;
                idx = 0;
                repeat (1499) begin
                    tick();
                    if (uart_tx_o === level) run++;
                    else begin
                        if (run % 10 != 0) bad_runs++;
                        if (idx < 6) runs[idx] = run;
                        idx++;
                        level = uart_tx_o;
                        run = 1;
                    end
                end
                if (run % 10 != 0) bad_runs++;
            end
        join
        tests++;
        if (busy_cnt != 1500) begin
            fails++;
            $display("FAIL busy_length: got %0d clocks, required 1500", busy_cnt);
        end
        tests++;
        if (bad_runs != 0) begin
            fails++;
            $display("FAIL bit_runs: got %0d runs not a multiple of 10, required 0", bad_runs);
        end
        tests++;
        if (runs[0] != 50 || runs[1] != 10 || runs[2] != 10 || runs[3] != 10 || runs[4] != 10) begin
            fails++;
            $display("FAIL first_char_runs: got %0d,%0d,%0d,%0d,%0d required 50,10,10,10,10",
                     runs[0], runs[1], runs[2], runs[3], runs[4]);
        end
        wait_sent("pass_msg");
        done_i = 1'b0;
    endtask

    task automatic run_message(input logic p, input logic [31:0] c, input string name);
        apply_reset();
        pass_i   = p;
        cycles_i = c;
        push_expected(p, c);
        done_i = 1'b1;
        tick();
        rx_message(15);
        wait_sent(name);
        done_i = 1'b0;
    endtask

    task automatic test_input_changes();
        int bad;
        apply_reset();
        pass_i   = 1'b1;
        cycles_i = 32'h00001A2F;
        push_expected(1'b1, 32'h00001A2F);
        done_i = 1'b1;
        tick();
        fork
            rx_message(15);
            begin
                repeat (299) tick();
                pass_i   = 1'b0;
                cycles_i = 32'd0;
                done_i   = 1'b0;
                tick();
                done_i = 1'b1;
                tick();
                done_i = 1'b0;
            end
        join
        wait_sent("changed_inputs");
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        bad = 0;
        repeat (2000) begin
            tick();
            if (uart_tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || sent_o !== 1'b1) begin
            fails++;
            $display("FAIL one_shot: got %0d active clocks sent %b, required 0 active sent 1", bad, sent_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pass_i   = 1'b0;
        cycles_i = 32'h9A9A9A9A;
        done_i   = 1'b1;
        tick();
        repeat (399) tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (uart_tx_o !== 1'b1 || busy_o !== 1'b0 || sent_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: got tx %b busy %b sent %b, required tx 1 busy 0 sent 0",
                     uart_tx_o, busy_o, sent_o);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        push_expected(1'b0, 32'h9A9A9A9A);
        tick();
        tests++;
        if (uart_tx_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL restart_after_reset: got tx %b busy %b, required tx 0 busy 1", uart_tx_o, busy_o);
        end
        rx_message(15);
        wait_sent("reset_restart");
        done_i = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        done_i   = 1'b0;
        pass_i   = 1'b0;
        cycles_i = 32'd0;
        test_reset();
        test_pass_message();
        run_message(1'b0, 32'hDEADBEEF, "fail_msg");
        test_input_changes();
        test_reset_mid();
        run_message(1'b1, 32'hFFFFFFFF, "all_f");
        run_message(1'b0, 32'h00000000, "all_zero");
        run_message(1'b1, 32'h9A9A9A9A, "digit_9a");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
